// File: rtl/task_sched_pkg.sv
// Shared types and constants for the task input scheduler.
// The optional burst limit is enabled by defining TASK_SCHED_BURST_LIMIT_EN.
package task_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES    = 2;
    localparam int FIFO_RD_LATENCY = 1;

    function automatic int wrap_idx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/task_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel strictly after ptr, with wrap.
// Used by task_input_scheduler (TASK_SCHED_BURST_LIMIT_EN has no effect here).
module task_rr_arbiter
    import task_sched_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         eligible,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [$clog2(N_CH)-1:0] winner,
    output logic                    found
);

    localparam int IW = $clog2(N_CH);

    // Walk from the farthest candidate back to ptr+1 so the nearest hit is written last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_CH; i >= 1; i--) begin
            if (eligible[wrap_idx(int'(ptr), i, N_CH)]) begin
                found  = 1'b1;
                winner = IW'(wrap_idx(int'(ptr), i, N_CH));
            end
        end
    end

endmodule

// File: rtl/task_input_scheduler.sv
// Round-robin scheduler draining N_CH task input FIFOs into one consumer.
// Define TASK_SCHED_BURST_LIMIT_EN to cap each grant at BURST_MAX words.
module task_input_scheduler
    import task_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CH-1:0]         i_empty,
    input  logic [N_CH-1:0]         i_busy,
    input  logic [N_CH*DW-1:0]      i_data,
    input  logic                    i_ready,
    output logic [N_CH-1:0]         o_req,
    output logic [DW-1:0]           o_data,
    output logic                    o_valid,
    output logic [$clog2(N_CH)-1:0] o_grant_id,
    output logic                    o_active,
    output logic                    o_done,
    output state_t                  o_state
);

    localparam int IW = $clog2(N_CH);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g;
    logic [1:0]      drain_cnt;
    logic [N_CH-1:0] eligible;
    logic [IW-1:0]   winner;
    logic            found;
    logic            burst_ok;
    logic            req_d1;
    logic [IW-1:0]   g_d1;

    assign eligible = ~i_empty & ~i_busy;
    assign o_state  = state;

`ifdef TASK_SCHED_BURST_LIMIT_EN
    localparam int CW = $clog2(BURST_MAX + 1);
    logic [CW-1:0] count;
    assign burst_ok = (count < CW'(BURST_MAX));
`else
    // Limit compiled out: any legal BURST_MAX leaves the grant unbounded.
    assign burst_ok = (BURST_MAX > 0);
`endif

    task_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .found    (found)
    );

    // Request is combinational so a FIFO that just went empty is never read again.
    always_comb begin
        o_req = '0;
        if (state == GRANT && !i_empty[g] && i_ready && burst_ok) begin
            o_req[g] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            ptr       <= IW'(N_CH - 1);
            g         <= '0;
            drain_cnt <= '0;
            o_active  <= 1'b0;
            o_done    <= 1'b0;
`ifdef TASK_SCHED_BURST_LIMIT_EN
            count     <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|eligible) state <= ARB;
                end
                ARB: begin
`ifdef TASK_SCHED_BURST_LIMIT_EN
                    count <= '0;
`endif
                    if (found) begin
                        g        <= winner;
                        ptr      <= winner;
                        o_active <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
`ifdef TASK_SCHED_BURST_LIMIT_EN
                    if (|o_req) count <= count + CW'(1);
`endif
                    if (i_empty[g] || i_busy[g] || !burst_ok) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        o_active <= 1'b0;
                        state    <= (|eligible) ? ARB : IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                        if (drain_cnt == 2'(DRAIN_CYCLES - 2)) o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One stage tracks the FIFO read latency, the second registers the muxed word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_d1     <= 1'b0;
            g_d1       <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_grant_id <= '0;
        end else begin
            req_d1  <= |o_req;
            g_d1    <= g;
            o_valid <= req_d1;
            if (req_d1) begin
                o_data     <= i_data[int'(g_d1)*DW +: DW];
                o_grant_id <= g_d1;
            end
        end
    end

endmodule

// File: tb/tb_task_input_scheduler.sv
// Directed bench for task_input_scheduler with FIFO models and a scoreboard monitor.
// Build with TASK_SCHED_BURST_LIMIT_EN to exercise the burst-limited ordering.
module tb_task_input_scheduler;
    import task_sched_pkg::*;

    localparam int N_CH  = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;
    localparam int W     = IW + DW;
    localparam int DEPTH = 128;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [N_CH-1:0]   i_empty;
    logic [N_CH-1:0]   i_busy = '0;
    logic [N_CH*DW-1:0] i_data;
    logic              i_ready = 1'b1;
    logic [N_CH-1:0]   o_req;
    logic [DW-1:0]     o_data;
    logic              o_valid;
    logic [IW-1:0]     o_grant_id;
    logic              o_active;
    logic              o_done;
    state_t            o_state;

    task_input_scheduler #(.N_CH(N_CH), .DW(DW), .BURST_MAX(4)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_empty    (i_empty),
        .i_busy     (i_busy),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_req      (o_req),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_grant_id (o_grant_id),
        .o_active   (o_active),
        .o_done     (o_done),
        .o_state    (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- FIFO models (1-cycle read latency) ----------------
    logic [DW-1:0] mem   [N_CH][DEPTH];
    int            wr_ptr[N_CH];
    int            rd_ptr[N_CH];
    logic [DW-1:0] q_reg [N_CH];

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            wr_ptr[k] = 0;
            rd_ptr[k] = 0;
            q_reg[k]  = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (o_req[k] && rd_ptr[k] != wr_ptr[k]) begin
                q_reg[k]  <= mem[k][rd_ptr[k] % DEPTH];
                rd_ptr[k] <= rd_ptr[k] + 1;
            end
        end
    end

    always_comb begin
        i_empty = '0;
        i_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            i_empty[k]         = (rd_ptr[k] == wr_ptr[k]);
            i_data[k*DW +: DW] = q_reg[k];
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int last_valid_cyc = 0;
    int run = 0;
    int last_run = 0;

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (o_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            run++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got id=%0d data=%02h, required no word", o_grant_id, o_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({o_grant_id, o_data} !== exp_w) begin
                    bad++;
                    $display("FAIL word_order: got id=%0d data=%02h, required id=%0d data=%02h",
                             o_grant_id, o_data, exp_w[W-1:DW], exp_w[DW-1:0]);
                end
            end
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (o_req != '0) begin
            total++;
            if (!$onehot(o_req) || (o_req & i_empty) != '0) begin
                bad++;
                $display("FAIL req_legal: got req=%b empty=%b, required one-hot on non-empty", o_req, i_empty);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic load(input int ch, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[ch][wr_ptr[ch] % DEPTH] = base + DW'(i);
            wr_ptr[ch] = wr_ptr[ch] + 1;
        end
    endtask

    task automatic expect_words(input int ch, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back({IW'(ch), base + DW'(i)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && o_state == IDLE && !o_active) ok = 1;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (o_done) ok = 1;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        int nreq;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid",  {31'd0, o_valid}, 32'd0);
        check("rst_data",   {24'd0, o_data}, 32'd0);
        check("rst_id",     {30'd0, o_grant_id}, 32'd0);
        check("rst_active", {31'd0, o_active}, 32'd0);
        check("rst_done",   {31'd0, o_done}, 32'd0);
        check("rst_req",    {28'd0, o_req}, 32'd0);
        check("rst_state",  {30'd0, o_state}, {30'd0, IDLE});
        @(negedge clk);
        i_rst = 1'b0;

        // Single channel, three words
        @(negedge clk);
        expect_words(1, 3, 8'hA1);
        load(1, 3, 8'hA1);
        wait_done("t1_done_seen", 40);
        check("t1_done_after_last", cyc - last_valid_cyc, 32'd1);
        check("t1_run_len", last_run, 32'd3);
        wait_quiet("t1_quiet", 40);

        // Two channels, then refill: ch0 wins again after ptr=2
        do_reset();
        expect_words(0, 2, 8'hB0);
        expect_words(2, 2, 8'hC0);
        load(0, 2, 8'hB0);
        load(2, 2, 8'hC0);
        wait_quiet("t2_round1", 60);
        @(negedge clk);
        expect_words(0, 2, 8'hD0);
        expect_words(2, 2, 8'hE0);
        load(0, 2, 8'hD0);
        load(2, 2, 8'hE0);
        wait_quiet("t2_round2", 60);

        // Long channel 0 against short channel 3
        do_reset();
`ifdef TASK_SCHED_BURST_LIMIT_EN
        expect_words(0, 4, 8'h10);
        expect_words(3, 2, 8'h30);
        expect_words(0, 4, 8'h14);
        expect_words(0, 2, 8'h18);
`else
        expect_words(0, 10, 8'h10);
        expect_words(3, 2, 8'h30);
`endif
        load(0, 10, 8'h10);
        load(3, 2, 8'h30);
        wait_quiet("t3_burst", 120);

        // Consumer back-pressure mid-grant
        @(negedge clk);
        expect_words(1, 8, 8'h40);
        v0 = valid_cnt;
        load(1, 8, 8'h40);
        for (int i = 0; i < 40 && (valid_cnt - v0) < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("t4_started", {31'd0, (valid_cnt - v0) >= 3}, 32'd1);
        i_ready = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t4_no_req_stalled", {28'd0, o_req}, 32'd0);
        end
        check("t4_inflight_le2", {31'd0, (valid_cnt - v0) <= 2}, 32'd1);
        i_ready = 1'b1;
        wait_quiet("t4_resume", 60);

        // Busy channel is skipped until it is released
        @(negedge clk);
        i_busy[2] = 1'b1;
        expect_words(1, 2, 8'h60);
        expect_words(2, 3, 8'h50);
        load(2, 3, 8'h50);
        load(1, 2, 8'h60);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t5_busy_no_req", {31'd0, o_req[2]}, 32'd0);
        end
        i_busy[2] = 1'b0;
        wait_quiet("t5_after_busy", 60);

        // Reset with two words in flight
        @(negedge clk);
        v0 = valid_cnt;
        load(0, 6, 8'h70);
        nreq = 0;
        for (int i = 0; i < 20 && nreq < 2; i++) begin
            @(negedge clk);
            #1;
            if (o_req[0]) nreq++;
        end
        check("t6_two_reqs", nreq, 32'd2);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_valid",  {31'd0, o_valid}, 32'd0);
        check("t6_data",   {24'd0, o_data}, 32'd0);
        check("t6_id",     {30'd0, o_grant_id}, 32'd0);
        check("t6_active", {31'd0, o_active}, 32'd0);
        check("t6_done",   {31'd0, o_done}, 32'd0);
        check("t6_req",    {28'd0, o_req}, 32'd0);
        check("t6_state",  {30'd0, o_state}, {30'd0, IDLE});
        @(negedge clk);
        wr_ptr[0] = rd_ptr[0];
        @(negedge clk);
        i_rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("t6_no_inflight", valid_cnt - v0, 32'd0);
        check("t6_sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task_input_scheduler.md
# task_input_scheduler

Round-robin scheduler that shares one downstream consumer between N task input buffers, each a FIFO that loads a stream and then releases words on request. It picks one eligible buffer (holding data, not loading), drains it word by word through its request line, and forwards the words with a valid strobe and source ID. It sits between the task input buffers and the task processing core.

## Interface
- N_CH, 4, number of input buffers, 2..8
- DW, 8, data word width
- BURST_MAX, 16, max words per grant (used only with burst limit compiled in)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_empty  in  N_CH  per-buffer FIFO empty flag
- i_busy  in  N_CH  per-buffer loading flag; buffer is ineligible while high
- i_data  in  N_CH*DW  per-buffer FIFO q; channel k at bits [k*DW +: DW]
- i_ready  in  1  consumer can take new words
- o_req  out  N_CH  one-hot FIFO read request to the granted buffer
- o_data  out  DW  forwarded word
- o_valid  out  1  o_data valid, single-cycle pulse per word
- o_grant_id  out  $clog2(N_CH)  channel that sourced o_data
- o_active  out  1  a grant is open (GRANT or DRAIN)
- o_done  out  1  one-cycle pulse when a grant's last word has been forwarded

## Operation
- Eligible[k] = !i_empty[k] && !i_busy[k].
- States:
  - IDLE → ARB when any channel is eligible.
  - ARB (1 cycle): register the winner, searching from ptr+1 upward with wrap; ptr = winner. Go to GRANT. If no channel is still eligible, return to IDLE.
  - GRANT: o_req[g] = !i_empty[g] && i_ready && burst_ok, combinational. The word counter increments per request. Go to DRAIN when i_empty[g] is high, or when i_busy[g] rises.
  - DRAIN (2 cycles): wait for in-flight words. o_done pulses on the last DRAIN cycle. Then go to ARB if any channel is eligible, otherwise IDLE.
- FIFO read latency is 1: a request at t gives q at t+1. The mux registers it, so o_data/o_valid/o_grant_id appear at t+2.
- A delayed copy of o_req drives o_valid. o_grant_id is the g registered with that word.
- The ptr advances only on grant, so each channel is served once per round while all are eligible.
- Reset values: o_req 0, o_data 0, o_valid 0, o_grant_id 0, o_active 0, o_done 0, ptr = N_CH-1 (first search starts at 0), state IDLE, counter 0.

## Timing
- i_empty reflects a request on the next cycle, and o_req tests it every cycle. There is no underflow, including on a 1-word FIFO.
- Deasserting i_ready stops new requests in the same cycle. Up to 2 in-flight words are still delivered, and the consumer must absorb them.
- Arbitration overhead between grants is 3 cycles (2 DRAIN + 1 ARB).
- Simultaneous eligible channels: the lowest index at or after ptr+1 wins.
- i_busy rising during GRANT: the grant ends and in-flight words are still forwarded.
- Reset mid-grant: all outputs are at reset values the next cycle, and in-flight words are discarded.

## Configuration
- TASK_SCHED_BURST_LIMIT_EN defined: burst_ok = (count < BURST_MAX). Reaching BURST_MAX goes to DRAIN even if data remains, and the channel re-competes in round-robin. The counter is $clog2(BURST_MAX+1) bits and clears in ARB.
- Not defined: burst_ok = 1. The grant is held until the FIFO is empty or the channel goes busy. The counter is absent.

## Structure
- Package task_sched_pkg holds:
  - the state typedef (IDLE, ARB, GRANT, DRAIN)
  - DRAIN_CYCLES = 2
  - FIFO_RD_LATENCY = 1
- Sub-module task_rr_arbiter: combinational round-robin pick. Inputs are the eligible vector and ptr; outputs are the winner index and a found flag.

## Test plan
- Channel 1 holds 3 words (0xA1..0xA3), others empty, i_ready=1 → o_valid on 3 consecutive cycles, o_grant_id=1, data in order, o_done one cycle after the last word.
- Channels 0 and 2 each hold 2 words → order ch0,ch0,ch2,ch2 and ptr=2; a refill of both serves ch0 first again.
- With TASK_SCHED_BURST_LIMIT_EN and BURST_MAX=4, ch0 holds 10 and ch3 holds 2 → ch0×4, ch3×2, ch0×4, ch0×2.
- i_ready dropped mid-grant for 5 cycles → at most 2 further o_valid, no o_req while low, no lost or duplicated word after resume.
- i_busy[2]=1 with i_empty[2]=0 → ch2 is never requested; it is granted after i_busy falls.
- i_rst asserted in GRANT with 2 words in flight → next cycle all outputs 0, state IDLE, and o_valid stays 0 for the in-flight words.
